morse_keyer: RTL and testbench

Transmit-side counterpart of the button classifier. Accepts 2-bit Morse symbol codes (dot, dash, send) into a small FIFO and replays them as a timed on/off key waveform with standard Morse unit ratios. Drives the LED/buzzer output stage and reports when the buffer is full or the transmitter is still sending.

---
 rtl/morse_pkg.sv | 20 ++
 rtl/morse_sym_fifo.sv | 53 +++++
 rtl/morse_keyer.sv | 151 +++++++++++++++
 tb/tb_morse_keyer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared symbol codes, keyer FSM states and Morse unit ratios for the keyer slice.
package morse_pkg;

  localparam logic [1:0] SYM_WAIT = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;
  localparam logic [1:0] SYM_SEND = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MARK = 2'd1,
    ST_GAP  = 2'd2,
    ST_LGAP = 2'd3
  } state_e;

  localparam int DOT_UNITS  = 1;
  localparam int DASH_UNITS = 3;
  localparam int LGAP_UNITS = 2;

endpackage

// File: rtl/morse_sym_fifo.sv
// First-word-fall-through symbol FIFO with full/empty flags; pointers reset asynchronously.
module morse_sym_fifo #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_fire, rd_fire;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_fire   = wr_en_i && !full_o;
  assign rd_fire   = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/morse_keyer.sv
// Morse keyer: buffers dot/dash/send symbols and replays them as a timed key waveform.
// Optional sidetone output enabled by defining MORSE_SIDETONE_EN.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES      = 5,
  parameter int FIFO_DEPTH       = 8,
  parameter int TONE_HALF_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sym_in,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic       key_out,
`ifdef MORSE_SIDETONE_EN
  output logic       busy,
  output logic       tone_out
`else
  output logic       busy
`endif
);

  localparam int CW = $clog2(3 * UNIT_CYCLES + 1);
  localparam logic [CW-1:0] DOT_LOAD  = CW'(DOT_UNITS * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] DASH_LOAD = CW'(DASH_UNITS * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] LGAP_LOAD = CW'(LGAP_UNITS * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(UNIT_CYCLES - 1);

  if (UNIT_CYCLES < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TONE_HALF_CYCLES < 1) begin : g_bad_param
    $error("morse_keyer: invalid parameter value");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pop, take_next;
  logic [1:0]      head_sym;
  logic            fifo_full, fifo_empty;

  morse_sym_fifo #(
    .DATA_W (2),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (sym_valid && (sym_in != SYM_WAIT)),
    .wr_data_i (sym_in),
    .rd_en_i   (pop),
    .rd_data_o (head_sym),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign sym_ready = !fifo_full;
  assign key_out   = (state_q == ST_MARK);
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    take_next = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      ST_IDLE: take_next = !fifo_empty;
      ST_MARK: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_GAP, ST_LGAP: begin
        // Chain straight into the next element so gaps are exactly their nominal length.
        if (cnt_q == '0) begin
          if (!fifo_empty) take_next = 1'b1;
          else             state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (take_next) begin
      pop = 1'b1;
      unique case (head_sym)
        SYM_DOT: begin
          state_d = ST_MARK;
          cnt_d   = DOT_LOAD;
        end
        SYM_DASH: begin
          state_d = ST_MARK;
          cnt_d   = DASH_LOAD;
        end
        default: begin
          state_d = ST_LGAP;
          cnt_d   = LGAP_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MORSE_SIDETONE_EN
  localparam int TW = $clog2(TONE_HALF_CYCLES + 1);
  localparam logic [TW-1:0] TONE_LOAD = TW'(TONE_HALF_CYCLES - 1);

  logic [TW-1:0] tone_cnt_q, tone_cnt_d;
  logic          tone_q, tone_d;

  // Phase restarts on every MARK entry so each element begins with the tone high.
  always_comb begin
    tone_cnt_d = tone_cnt_q;
    tone_d     = tone_q;
    if (state_d == ST_MARK && state_q != ST_MARK) begin
      tone_d     = 1'b1;
      tone_cnt_d = TONE_LOAD;
    end else if (state_q == ST_MARK) begin
      if (tone_cnt_q == '0) begin
        tone_d     = !tone_q;
        tone_cnt_d = TONE_LOAD;
      end else begin
        tone_cnt_d = tone_cnt_q - TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
    end else begin
      tone_cnt_q <= tone_cnt_d;
      tone_q     <= tone_d;
    end
  end

  assign tone_out = tone_q && (state_q == ST_MARK);
`endif

endmodule

// File: tb/tb_morse_keyer.sv
// Self-checking bench for morse_keyer: segment-list reference model plus directed scenarios.
module tb_morse_keyer;

  localparam int U     = 5;
  localparam int DEPTH = 8;
  localparam int THC   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] sym_in = 2'b00;
  logic       sym_valid = 1'b0;
  logic       sym_ready, key_out, busy;
`ifdef MORSE_SIDETONE_EN
  logic       tone_out;
`endif

  always #5 clk = ~clk;

  morse_keyer #(
    .UNIT_CYCLES      (U),
    .FIFO_DEPTH       (DEPTH),
    .TONE_HALF_CYCLES (THC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .key_out   (key_out),
`ifdef MORSE_SIDETONE_EN
    .busy      (busy),
    .tone_out  (tone_out)
`else
    .busy      (busy)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: accepted symbols queue up, and the transmitter plays each
  // symbol as a list of (level, length) segments back to back.
  int fq[$];
  int seg_lvl[$];
  int seg_len[$];
  int seg_left[$];

  function automatic void add_seg(input int lvl, input int len);
    seg_lvl.push_back(lvl);
    seg_len.push_back(len);
    seg_left.push_back(len);
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int pre;
    int s;
    if (rst) begin
      fq.delete();
      seg_lvl.delete();
      seg_len.delete();
      seg_left.delete();
    end else begin
      pre = fq.size();
      if (seg_left.size() > 0) begin
        seg_left[0] = seg_left[0] - 1;
        if (seg_left[0] == 0) begin
          void'(seg_lvl.pop_front());
          void'(seg_len.pop_front());
          void'(seg_left.pop_front());
        end
      end
      if (seg_left.size() == 0 && pre > 0) begin
        s = fq.pop_front();
        if (s == 1) begin
          add_seg(1, U);
          add_seg(0, U);
        end else if (s == 2) begin
          add_seg(1, 3 * U);
          add_seg(0, U);
        end else begin
          add_seg(0, 2 * U);
        end
      end
      if (sym_valid && pre < DEPTH && sym_in != 2'b00) fq.push_back(int'(sym_in));
    end
  end

  always @(negedge clk) begin : compare
    int ek, eb, er;
    ek = (seg_left.size() > 0 && seg_lvl[0] == 1) ? 1 : 0;
    eb = (seg_left.size() > 0 || fq.size() > 0) ? 1 : 0;
    er = (fq.size() < DEPTH) ? 1 : 0;
    check("key_out", int'(key_out), ek);
    check("busy", int'(busy), eb);
    check("sym_ready", int'(sym_ready), er);
`ifdef MORSE_SIDETONE_EN
    begin
      int et;
      et = 0;
      if (ek == 1 && (((seg_len[0] - seg_left[0]) / THC) % 2) == 0) et = 1;
      check("tone_out", int'(tone_out), et);
    end
`endif
  end

  // Transition log of key_out (in negedge-sample cycles) and last busy fall.
  int   cyc = 0;
  int   tr_cyc[$];
  int   busy_fall = -1;
  logic last_key = 1'b0;
  logic last_busy = 1'b0;

  always @(negedge clk) begin : monitor
    cyc++;
    if (key_out !== last_key) tr_cyc.push_back(cyc);
    last_key = key_out;
    if (last_busy && !busy) busy_fall = cyc;
    last_busy = busy;
  end

  task automatic put(input logic [1:0] s);
    int n;
    sym_in    = s;
    sym_valid = 1'b1;
    n = 0;
    while (!sym_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("put_ready_wait_bound", int'(n >= 500), 0);
    @(negedge clk);
    sym_valid = 1'b0;
    sym_in    = 2'b00;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < bound);
    check("idle_wait_bound", int'(n >= bound), 0);
    #1;
  endtask

  initial begin : stim
    int idx;
    int exp_runs[5];
    exp_runs = '{15, 5, 5, 15, 5};

    // Reset state and writes ignored during reset
    #1 rst = 1'b1;
    #1;
    check("rst_key", int'(key_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(sym_ready), 1);
    @(negedge clk);
    sym_in = 2'b01;
    sym_valid = 1'b1;
    @(negedge clk);
    sym_valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("wr_during_rst_busy", int'(busy), 0);

    // Single dot: latency, 5-cycle mark, busy clears 5 cycles after fall
    #1 idx = tr_cyc.size();
    put(2'b01);
    check("dot_pre_rise", int'(key_out), 0);
    @(negedge clk);
    check("dot_rise", int'(key_out), 1);
    wait_idle(100);
    check("dot_edges", tr_cyc.size() - idx, 2);
    if (tr_cyc.size() - idx == 2) begin
      check("dot_high_len", tr_cyc[idx+1] - tr_cyc[idx], 5);
      check("dot_busy_tail", busy_fall - tr_cyc[idx+1], 5);
    end

    // dash, dot, send, dot
    idx = tr_cyc.size();
    put(2'b10);
    put(2'b01);
    put(2'b11);
    put(2'b01);
    wait_idle(300);
    check("seq_edges", tr_cyc.size() - idx, 6);
    if (tr_cyc.size() - idx == 6) begin
      for (int i = 0; i < 5; i++)
        check($sformatf("seq_run%0d", i), tr_cyc[idx+i+1] - tr_cyc[idx+i], exp_runs[i]);
      check("seq_busy_tail", busy_fall - tr_cyc[idx+5], 5);
    end

    // Wait code is discarded
    idx = tr_cyc.size();
    put(2'b00);
    check("wait_busy", int'(busy), 0);
    repeat (10) @(negedge clk);
    #1;
    check("wait_key_edges", tr_cyc.size() - idx, 0);
    check("wait_busy_late", int'(busy), 0);

    // Overfill: 9 dashes fill the FIFO, a 10th is held until space frees up
    idx = tr_cyc.size();
    for (int i = 0; i < 9; i++) put(2'b10);
    check("full_ready_low", int'(sym_ready), 0);
    put(2'b10);
    wait_idle(2000);
    check("ten_dashes_edges", tr_cyc.size() - idx, 20);

    // Reset in the middle of a dash with more symbols queued
    put(2'b10);
    put(2'b01);
    put(2'b01);
    repeat (6) @(negedge clk);
    check("pre_rst_key", int'(key_out), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_key", int'(key_out), 0);
    check("async_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1 idx = tr_cyc.size();
    repeat (40) @(negedge clk);
    #1;
    check("post_rst_edges", tr_cyc.size() - idx, 0);
    check("post_rst_busy", int'(busy), 0);

`ifdef MORSE_SIDETONE_EN
    begin
      int pat[5];
      pat = '{1, 1, 0, 0, 1};
      put(2'b01);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check($sformatf("tone_pat%0d", i), int'(tone_out), pat[i]);
      end
      @(negedge clk);
      check("tone_gap", int'(tone_out), 0);
      wait_idle(100);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
